banco_sb: RTL and testbench
===========================

Name: banco_sb

Overview:
- Parametrised successor to the single-cycle register bank: synchronous write, combinational reads with write-through bypass, and optional hardwired-zero register 0.
- Adds a per-register pending scoreboard: issue reserves a destination, writeback clears it.
- Flags RAW/WAW hazards so the decode/issue stage can stall.
- Sits between decode (ra1/ra2/ar/ResEn) and writeback (RegEn/aw/dataIn_b).

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of registers (need not be a power of two)
AW, 5, address width; must satisfy 2**AW >= DEPTH
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle writeback data and clear are visible on read ports

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
RegEn  input  1  writeback enable
aw  input  AW  writeback address
dataIn_b  input  WIDTH  writeback data
ra1  input  AW  read address, port 1
ra2  input  AW  read address, port 2
dr1  output  WIDTH  read data, port 1 (combinational)
dr2  output  WIDTH  read data, port 2 (combinational)
ResEn  input  1  issue request: reserve destination ar
ar  input  AW  destination to reserve
busy1  output  1  ra1 has a pending write
busy2  output  1  ra2 has a pending write
stall  output  1  issue must hold this cycle
pend  output  DEPTH  pending vector, bit i = register i reserved

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n). While rst_n=0: all registers = 0, pend = 0. Outputs are combinational on state: dr1/dr2 = 0, busy1/busy2 = 0. stall = 0 unless the WAW term applies; pend = 0, so stall = 0 during reset.
- "valid(a)": a < DEPTH and not (ZERO_REG=1 and a==0).
- Write: at posedge, if RegEn and valid(aw): mem[aw] <= dataIn_b; pend[aw] <= 0. Writes to invalid addresses are dropped silently.
- Reserve: at posedge, if ResEn and not stall and valid(ar): pend[ar] <= 1. Reserving an invalid address is accepted but has no effect.
- Same-edge write and reserve to the same register: data is written, and pend ends at 1 (the new reservation wins).
- Writeback to a non-pending register is legal; it writes data and pend stays 0.
- Read port n, evaluated in priority order:
  - ra_n invalid (out of range, or reg 0 with ZERO_REG=1) -> 0.
  - BYPASS=1 and RegEn and aw==ra_n -> dataIn_b.
  - Otherwise -> mem[ra_n].
- busy_n = valid(ra_n) and pend[ra_n], except it is forced to 0 when BYPASS=1 and RegEn and aw==ra_n.
- stall = busy1 or busy2 or waw.
  - waw = ResEn and valid(ar) and pend[ar], except it is forced to 0 when BYPASS=1 and RegEn and aw==ar.
  - stall does not depend on ResEn for the RAW terms. The issue stage qualifies it.
- With BYPASS=0, a read of the register being written this cycle returns the old value, and busy stays 1 until the cycle after writeback.
- Latency:
  - Written data is readable via mem one cycle after the write edge; with BYPASS=1 it is visible in the same cycle.
  - A reservation is visible on pend/busy one cycle after its edge.
- Reset asserted mid-operation clears every pending bit immediately. In-flight writebacks after reset deassertion write data normally.
- No X propagation: all mem entries reset to 0. The reset loop covers only indices < DEPTH.

Test Plan:
- Reset, then read ra1=3, ra2=0 -> dr1=0, dr2=0, pend=0, stall=0. Then write aw=3, data 0xDEADBEEF. Next cycle ra1=3 -> dr1=0xDEADBEEF.
- ZERO_REG=1: RegEn aw=0 data 0x12345678, and ResEn ar=0 -> dr1 at ra1=0 stays 0; pend[0] stays 0; stall=0.
- RAW: ResEn ar=5 (accepted) -> pend[5]=1 next cycle. Then ra1=5 -> busy1=1, stall=1. In the same cycle RegEn aw=5 data 0xA5A5A5A5 with BYPASS=1 -> dr1=0xA5A5A5A5, busy1=0, stall=0. Next cycle pend[5]=0.
- WAW: pend[7]=1, ResEn ar=7, no writeback -> stall=1 and pend unchanged. Then writeback aw=7 in the same cycle as ResEn ar=7 -> stall=0; after the edge, mem[7] is updated and pend[7]=1.
- BYPASS=0, DEPTH=24: mem[2]=0x11. Same-cycle write aw=2 data 0x22 with ra2=2 -> dr2=0x11; 0x22 on the next cycle. Write aw=30 -> ignored; ra1=30 -> dr1=0, busy1=0.
- Reset mid-operation: pend=0x000000A0. Drop rst_n asynchronously between edges -> pend=0 and dr outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/banco_sb.sv
// Register bank with combinational bypassed reads and a per-register
// pending scoreboard for RAW/WAW hazard stalls.
module banco_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegEn,
  input  logic [AW-1:0]    aw,
  input  logic [WIDTH-1:0] dataIn_b,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] dr1,
  output logic [WIDTH-1:0] dr2,
  input  logic             ResEn,
  input  logic [AW-1:0]    ar,
  output logic             busy1,
  output logic             busy2,
  output logic             stall,
  output logic [DEPTH-1:0] pend
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  logic v_aw, v_ar, v_ra1, v_ra2;
  logic we, res_acc, waw;
  logic byp1, byp2, bypr;

  function automatic logic valid(input logic [AW-1:0] a);
    logic ok;
    ok = (32'(a) < DEPTH);
    if (ZERO_REG && a == '0) ok = 1'b0;
    return ok;
  endfunction

  assign v_aw  = valid(aw);
  assign v_ar  = valid(ar);
  assign v_ra1 = valid(ra1);
  assign v_ra2 = valid(ra2);

  assign we = RegEn && v_aw;

  // Bypass is gated by reset so read ports stay 0 while held in reset.
  assign byp1 = BYPASS && RegEn && rst_n && (aw == ra1);
  assign byp2 = BYPASS && RegEn && rst_n && (aw == ra2);
  assign bypr = BYPASS && RegEn && rst_n && (aw == ar);

  always_comb begin
    dr1 = '0;
    if (v_ra1) dr1 = byp1 ? dataIn_b : mem_q[ra1];
  end

  always_comb begin
    dr2 = '0;
    if (v_ra2) dr2 = byp2 ? dataIn_b : mem_q[ra2];
  end

  assign busy1 = v_ra1 && pend_q[ra1] && !byp1;
  assign busy2 = v_ra2 && pend_q[ra2] && !byp2;
  assign waw   = ResEn && v_ar && pend_q[ar] && !bypr;
  assign stall = busy1 || busy2 || waw;

  assign res_acc = ResEn && !stall && v_ar;

  // Reservation is applied after the clear so it wins on the same register.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && aw == AW'(i)) pend_d[i] = 1'b0;
      if (res_acc && ar == AW'(i)) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (we && aw == AW'(i)) mem_q[i] <= dataIn_b;
      end
    end
  end

  assign pend = pend_q;

endmodule

// File: tb/tb_banco_sb.sv
// Directed bench for banco_sb: default bank plus a BYPASS=0, DEPTH=24 bank.
module tb_banco_sb;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        RegEn, ResEn;
  logic [4:0]  aw, ra1, ra2, ar;
  logic [31:0] din;
  logic [31:0] dr1, dr2;
  logic        busy1, busy2, stall;
  logic [31:0] pend;

  logic        bRegEn, bResEn;
  logic [4:0]  baw, bra1, bra2, bar;
  logic [31:0] bdin;
  logic [31:0] bdr1, bdr2;
  logic        bbusy1, bbusy2, bstall;
  logic [23:0] bpend;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  banco_sb u0 (
    .clk(clk), .rst_n(rst_n), .RegEn(RegEn), .aw(aw),
    .dataIn_b(din), .ra1(ra1), .ra2(ra2), .dr1(dr1), .dr2(dr2),
    .ResEn(ResEn), .ar(ar), .busy1(busy1), .busy2(busy2),
    .stall(stall), .pend(pend)
  );

  banco_sb #(.DEPTH(24), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .RegEn(bRegEn), .aw(baw),
    .dataIn_b(bdin), .ra1(bra1), .ra2(bra2), .dr1(bdr1), .dr2(bdr2),
    .ResEn(bResEn), .ar(bar), .busy1(bbusy1), .busy2(bbusy2),
    .stall(bstall), .pend(bpend)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    RegEn = 0; ResEn = 0; aw = 0; ar = 0; din = 0;
    ra1 = 5'd3; ra2 = 5'd0;
    bRegEn = 0; bResEn = 0; baw = 0; bar = 0; bdin = 0;
    bra1 = 0; bra2 = 0;
    #1;
    chk("rst_dr1", dr1, 0);
    chk("rst_dr2", dr2, 0);
    chk("rst_pend", pend, 0);
    chk("rst_stall", stall, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic write with bypass, then read from mem
    RegEn = 1; aw = 5'd3; din = 32'hDEADBEEF;
    #1 chk("wr3_byp", dr1, 32'hDEADBEEF);
    tick();
    RegEn = 0;
    #1 chk("wr3_mem", dr1, 32'hDEADBEEF);

    // Register 0 hardwired
    RegEn = 1; aw = 0; din = 32'h12345678;
    ResEn = 1; ar = 0; ra1 = 0;
    #1 chk("z_dr1", dr1, 0);
    chk("z_stall", stall, 0);
    tick();
    RegEn = 0; ResEn = 0;
    #1 chk("z_dr1_after", dr1, 0);
    chk("z_pend", pend, 0);

    // RAW
    ra1 = 5'd3; ra2 = 5'd3;
    ResEn = 1; ar = 5'd5;
    #1 chk("raw_res_stall", stall, 0);
    tick();
    ResEn = 0;
    #1 chk("raw_pend5", pend, 32'h20);
    ra1 = 5'd5;
    #1 chk("raw_busy1", busy1, 1);
    chk("raw_stall", stall, 1);
    RegEn = 1; aw = 5'd5; din = 32'hA5A5A5A5;
    #1 chk("raw_byp_dr1", dr1, 32'hA5A5A5A5);
    chk("raw_byp_busy1", busy1, 0);
    chk("raw_byp_stall", stall, 0);
    tick();
    RegEn = 0;
    #1 chk("raw_pend_clr", pend, 0);
    chk("raw_mem5", dr1, 32'hA5A5A5A5);

    // WAW
    ra1 = 5'd3; ra2 = 5'd3;
    ResEn = 1; ar = 5'd7;
    tick();
    #1 chk("waw_pend7", pend, 32'h80);
    chk("waw_stall", stall, 1);
    tick();
    #1 chk("waw_pend_hold", pend, 32'h80);
    RegEn = 1; aw = 5'd7; din = 32'h77;
    #1 chk("waw_byp_stall", stall, 0);
    tick();
    RegEn = 0; ResEn = 0;
    ra1 = 5'd7;
    #1 chk("waw_pend_after", pend, 32'h80);
    chk("waw_mem7", dr1, 32'h77);
    chk("waw_busy1", busy1, 1);

    // BYPASS=0, DEPTH=24 bank
    bRegEn = 1; baw = 5'd2; bdin = 32'h11;
    tick();
    bdin = 32'h22; bra2 = 5'd2;
    #1 chk("nb_old", bdr2, 32'h11);
    tick();
    bRegEn = 0;
    #1 chk("nb_new", bdr2, 32'h22);
    bRegEn = 1; baw = 5'd30; bdin = 32'h99; bra1 = 5'd30;
    #1 chk("nb_oor_dr1", bdr1, 0);
    chk("nb_oor_busy1", bbusy1, 0);
    tick();
    bRegEn = 0;
    #1 chk("nb_oor_dr1_after", bdr1, 0);
    chk("nb_oor_pend", bpend, 0);
    bResEn = 1; bar = 5'd4;
    tick();
    bResEn = 0;
    #1 chk("nb_pend4", bpend, 24'h10);
    bRegEn = 1; baw = 5'd4; bdin = 32'h44; bra1 = 5'd4;
    #1 chk("nb_busy_wb", bbusy1, 1);
    chk("nb_dr_wb_old", bdr1, 0);
    tick();
    bRegEn = 0;
    #1 chk("nb_busy_clr", bbusy1, 0);
    chk("nb_dr_wb_new", bdr1, 32'h44);

    // Async reset mid-operation
    ra1 = 5'd3; ra2 = 5'd3;
    ResEn = 1; ar = 5'd5;
    tick();
    ResEn = 0;
    #1 chk("mid_pend", pend, 32'hA0);
    chk("mid_dr1", dr1, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_pend", pend, 0);
    chk("mid_rst_dr1", dr1, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_bpend", bpend, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
